fix_order_arbiter: RTL

//  Shares one FIX order encoder among N_REQ strategy requesters.
//  - Round-robin arbitration.
//  - Validates order side.
//  - Stamps each accepted order with a sequential client order ID.
//  - Rate-limits with a token bucket.
//  - Sequences the encoder's order_valid / fix_ready_in handshake, with a completion timeout.

---
 rtl/fix_order_arbiter.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/fix_order_arbiter.sv
// fix_order_arbiter: shares one FIX order encoder among N_REQ strategy requesters.
// Round-robin grant, side validation, sequential client order IDs, token-bucket
// rate limiting and an order_valid / ready handshake with a completion timeout.
module fix_order_arbiter #(
    parameter int          N_REQ          = 4,
    parameter logic [31:0] ID_BASE        = 32'd1,
    parameter int          BURST          = 8,
    parameter int          REFILL_CYCLES  = 1000,
    parameter int          TIMEOUT_CYCLES = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ-1:0]      req_enable,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*64-1:0]   req_symbol,
    input  logic [N_REQ*32-1:0]   req_qty,
    input  logic [N_REQ*32-1:0]   req_price,
    input  logic [N_REQ*8-1:0]    req_side,
    output logic [63:0]           enc_symbol,
    output logic [31:0]           enc_qty,
    output logic [31:0]           enc_price,
    output logic [7:0]            enc_side,
    output logic [31:0]           enc_cl_ord_id,
    output logic                  enc_order_valid,
    input  logic                  enc_ready,
    output logic [2:0]            grant_id,
    output logic [31:0]           orders_sent,
    output logic [31:0]           orders_rejected,
    output logic [31:0]           throttle_stalls,
    output logic [31:0]           timeout_errors
);

    localparam int TOK_W = $clog2(BURST + 1);
    localparam int REF_W = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ACCEPT    = 3'd1;
    localparam logic [2:0] S_ISSUE     = 3'd2;
    localparam logic [2:0] S_WAIT_ACK  = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [2:0]       rr_ptr_q, rr_ptr_d;
    logic [2:0]       win_q, win_d;
    logic [31:0]      next_id_q, next_id_d;
    logic [TOK_W-1:0] tokens_q, tokens_d;
    logic [REF_W-1:0] refill_cnt_q, refill_cnt_d;
    logic [TMO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [N_REQ-1:0] req_ready_q, req_ready_d;
    logic [2:0]       grant_id_q, grant_id_d;
    logic [63:0]      enc_symbol_q, enc_symbol_d;
    logic [31:0]      enc_qty_q, enc_qty_d;
    logic [31:0]      enc_price_q, enc_price_d;
    logic [7:0]       enc_side_q, enc_side_d;
    logic [31:0]      enc_cl_ord_id_q, enc_cl_ord_id_d;
    logic             enc_order_valid_q, enc_order_valid_d;
    logic [31:0]      orders_sent_q, orders_sent_d;
    logic [31:0]      orders_rejected_q, orders_rejected_d;
    logic [31:0]      throttle_stalls_q, throttle_stalls_d;
    logic [31:0]      timeout_errors_q, timeout_errors_d;

    logic [N_REQ-1:0]   eligible_s;
    logic [2*N_REQ-1:0] elig_rot_s;
    logic               any_elig_s;
    logic [2:0]         win_s;
    logic [63:0]        sel_symbol_s;
    logic [31:0]        sel_qty_s;
    logic [31:0]        sel_price_s;
    logic [7:0]         sel_side_s;
    logic               sel_valid_s;
    logic               side_ok_s;
    logic               refill_tick_s;
    logic               consume_s;

    // Round-robin pick: rotate eligibility so rr_ptr sits at bit 0, lowest set bit wins.
    always_comb begin
        eligible_s = req_valid & req_enable;
        elig_rot_s = {eligible_s, eligible_s} >> rr_ptr_q;
        any_elig_s = |eligible_s;
        win_s      = 3'd0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            win_s = elig_rot_s[k] ? 3'((int'(rr_ptr_q) + k) % N_REQ) : win_s;
        end
    end

    // Payload of the requester currently holding the grant.
    always_comb begin
        sel_symbol_s = 64'd0;
        sel_qty_s    = 32'd0;
        sel_price_s  = 32'd0;
        sel_side_s   = 8'd0;
        sel_valid_s  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_symbol_s = (win_q == 3'(i)) ? req_symbol[i*64 +: 64] : sel_symbol_s;
            sel_qty_s    = (win_q == 3'(i)) ? req_qty[i*32 +: 32]    : sel_qty_s;
            sel_price_s  = (win_q == 3'(i)) ? req_price[i*32 +: 32]  : sel_price_s;
            sel_side_s   = (win_q == 3'(i)) ? req_side[i*8 +: 8]     : sel_side_s;
            sel_valid_s  = (win_q == 3'(i)) ? req_valid[i]           : sel_valid_s;
        end
        side_ok_s = (sel_side_s == 8'd1) || (sel_side_s == 8'd2);
    end

    // Order sequencing state machine and statistics counters.
    always_comb begin
        state_d           = state_q;
        rr_ptr_d          = rr_ptr_q;
        win_d             = win_q;
        next_id_d         = next_id_q;
        wait_cnt_d        = wait_cnt_q;
        req_ready_d       = '0;
        grant_id_d        = grant_id_q;
        enc_symbol_d      = enc_symbol_q;
        enc_qty_d         = enc_qty_q;
        enc_price_d       = enc_price_q;
        enc_side_d        = enc_side_q;
        enc_cl_ord_id_d   = enc_cl_ord_id_q;
        enc_order_valid_d = 1'b0;
        orders_sent_d     = orders_sent_q;
        orders_rejected_d = orders_rejected_q;
        throttle_stalls_d = throttle_stalls_q;
        timeout_errors_d  = timeout_errors_q;
        consume_s         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enc_ready && any_elig_s && (tokens_q != '0)) begin
                    for (int i = 0; i < N_REQ; i++) begin
                        req_ready_d[i] = (win_s == 3'(i));
                    end
                    grant_id_d = win_s;
                    win_d      = win_s;
                    state_d    = S_ACCEPT;
                end else if (enc_ready && any_elig_s) begin
                    throttle_stalls_d = throttle_stalls_q + 32'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCEPT: begin
                if (sel_valid_s) begin
                    rr_ptr_d = (win_q == 3'(N_REQ - 1)) ? 3'd0 : win_q + 3'd1;
                    if (side_ok_s) begin
                        enc_symbol_d      = sel_symbol_s;
                        enc_qty_d         = sel_qty_s;
                        enc_price_d       = sel_price_s;
                        enc_side_d        = sel_side_s;
                        enc_cl_ord_id_d   = next_id_q;
                        next_id_d         = next_id_q + 32'd1;
                        consume_s         = 1'b1;
                        enc_order_valid_d = 1'b1;
                        state_d           = S_ISSUE;
                    end else begin
                        orders_rejected_d = orders_rejected_q + 32'd1;
                        state_d           = S_IDLE;
                    end
                end else begin
                    // Requester withdrew during the accept cycle: drop silently.
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (!enc_ready) begin
                    wait_cnt_d = '0;
                    state_d    = S_WAIT_DONE;
                end else begin
                    // Encoder never went busy, so it did not take the order.
                    timeout_errors_d = timeout_errors_q + 32'd1;
                    state_d          = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (enc_ready) begin
                    orders_sent_d = orders_sent_q + 32'd1;
                    state_d       = S_IDLE;
                end else if (wait_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_errors_d = timeout_errors_q + 32'd1;
                    state_d          = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + TMO_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Token bucket: periodic refill saturating at BURST; refill plus consume cancel out.
    always_comb begin
        refill_tick_s = (refill_cnt_q == REF_W'(REFILL_CYCLES - 1));
        refill_cnt_d  = refill_tick_s ? '0 : refill_cnt_q + REF_W'(1);
        if (refill_tick_s && !consume_s) begin
            tokens_d = (tokens_q == TOK_W'(BURST)) ? tokens_q : tokens_q + TOK_W'(1);
        end else if (consume_s && !refill_tick_s) begin
            tokens_d = tokens_q - TOK_W'(1);
        end else begin
            tokens_d = tokens_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= S_IDLE;
            rr_ptr_q          <= 3'd0;
            win_q             <= 3'd0;
            next_id_q         <= ID_BASE;
            tokens_q          <= TOK_W'(BURST);
            refill_cnt_q      <= '0;
            wait_cnt_q        <= '0;
            req_ready_q       <= '0;
            grant_id_q        <= 3'd0;
            enc_symbol_q      <= 64'd0;
            enc_qty_q         <= 32'd0;
            enc_price_q       <= 32'd0;
            enc_side_q        <= 8'd0;
            enc_cl_ord_id_q   <= 32'd0;
            enc_order_valid_q <= 1'b0;
            orders_sent_q     <= 32'd0;
            orders_rejected_q <= 32'd0;
            throttle_stalls_q <= 32'd0;
            timeout_errors_q  <= 32'd0;
        end else begin
            state_q           <= state_d;
            rr_ptr_q          <= rr_ptr_d;
            win_q             <= win_d;
            next_id_q         <= next_id_d;
            tokens_q          <= tokens_d;
            refill_cnt_q      <= refill_cnt_d;
            wait_cnt_q        <= wait_cnt_d;
            req_ready_q       <= req_ready_d;
            grant_id_q        <= grant_id_d;
            enc_symbol_q      <= enc_symbol_d;
            enc_qty_q         <= enc_qty_d;
            enc_price_q       <= enc_price_d;
            enc_side_q        <= enc_side_d;
            enc_cl_ord_id_q   <= enc_cl_ord_id_d;
            enc_order_valid_q <= enc_order_valid_d;
            orders_sent_q     <= orders_sent_d;
            orders_rejected_q <= orders_rejected_d;
            throttle_stalls_q <= throttle_stalls_d;
            timeout_errors_q  <= timeout_errors_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign grant_id        = grant_id_q;
    assign enc_symbol      = enc_symbol_q;
    assign enc_qty         = enc_qty_q;
    assign enc_price       = enc_price_q;
    assign enc_side        = enc_side_q;
    assign enc_cl_ord_id   = enc_cl_ord_id_q;
    assign enc_order_valid = enc_order_valid_q;
    assign orders_sent     = orders_sent_q;
    assign orders_rejected = orders_rejected_q;
    assign throttle_stalls = throttle_stalls_q;
    assign timeout_errors  = timeout_errors_q;

endmodule
